// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: segment table, blank pattern
// and handshake FSM state encoding.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g patterns, index 15 (F) first so SEG_TABLE[n] decodes nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/hex_display_ctrl_seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment decoder with a blank override.
module seg7_hex_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[value];
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: valid/ready value capture, leading-zero
// suppression, per-digit blink, and either static or time-multiplexed scan outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int SCAN_MODE = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic                  in_lz_blank,
  input  logic [DIGITS-1:0]     in_blink_mask,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic [6:0]            scan_seg,
  output logic [DIGITS-1:0]     scan_an
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Handshake: a value transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid seen during COMMIT is ignored.
  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   shadow_value_q, shadow_value_d;
  logic                  shadow_lz_q, shadow_lz_d;
  logic [DIGITS-1:0]     shadow_mask_q, shadow_mask_d;
  logic [4*DIGITS-1:0]   disp_value_q, disp_value_d;
  logic                  disp_lz_q, disp_lz_d;
  logic [DIGITS-1:0]     disp_mask_q, disp_mask_d;
  logic                  blank_all_q, blank_all_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         digit_idx_q, digit_idx_d;
  logic [7*DIGITS-1:0]   hex_out_q, hex_out_d;
  logic [6:0]            scan_seg_q, scan_seg_d;
  logic [DIGITS-1:0]     scan_an_q, scan_an_d;

  logic                  blink_wrap;
  logic                  scan_tick;
  logic                  commit_ok;
  logic                  lz_run;
  logic [DIGITS-1:0]     dig_blank;

  assign in_ready = (state_q == ST_IDLE);
  assign hex_out  = hex_out_q;
  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;

  always_comb begin
    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    scan_tick     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    if (scan_tick) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end
    // Scan mode only swaps the display at the end of a frame so digits never tear.
    commit_ok = (SCAN_MODE == 0) ? 1'b1 : (scan_tick && (digit_idx_q == IDX_LAST));
  end

  always_comb begin
    state_d        = state_q;
    shadow_value_d = shadow_value_q;
    shadow_lz_d    = shadow_lz_q;
    shadow_mask_d  = shadow_mask_q;
    disp_value_d   = disp_value_q;
    disp_lz_d      = disp_lz_q;
    disp_mask_d    = disp_mask_q;
    blank_all_d    = blank_all_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shadow_value_d = in_value;
          shadow_lz_d    = in_lz_blank;
          shadow_mask_d  = in_blink_mask;
          state_d        = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (commit_ok) begin
          disp_value_d = shadow_value_q;
          disp_lz_d    = shadow_lz_q;
          disp_mask_d  = shadow_mask_q;
          blank_all_d  = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leading zeros blank from the top digit down until the first non-zero; digit 0 always shows.
  always_comb begin
    lz_run    = disp_lz_q;
    dig_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig_blank[i] = blank_all_q | (disp_mask_q[i] & blink_phase_q);
      if ((i != 0) && lz_run && (disp_value_q[4*i +: 4] == 4'h0)) begin
        dig_blank[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  if (SCAN_MODE == 0) begin : g_static
    logic [7*DIGITS-1:0] seg_all;
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_hex_decoder u_dec (
        .value (disp_value_q[4*g +: 4]),
        .blank (dig_blank[g]),
        .seg   (seg_all[7*g +: 7])
      );
    end
    always_comb begin
      hex_out_d  = seg_all;
      scan_seg_d = SEG_BLANK;
      scan_an_d  = '1;
    end
  end else begin : g_scan
    logic [3:0] sel_value;
    logic       sel_blank;
    logic [6:0] sel_seg;
    always_comb begin
      sel_value = 4'h0;
      sel_blank = 1'b1;
      scan_an_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_idx_q == IW'(i)) begin
          sel_value    = disp_value_q[4*i +: 4];
          sel_blank    = dig_blank[i];
          scan_an_d[i] = blank_all_q;
        end
      end
    end
    seg7_hex_decoder u_dec (
      .value (sel_value),
      .blank (sel_blank),
      .seg   (sel_seg)
    );
    always_comb begin
      hex_out_d  = '1;
      scan_seg_d = sel_seg;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      shadow_value_q <= '0;
      shadow_lz_q    <= 1'b0;
      shadow_mask_q  <= '0;
      disp_value_q   <= '0;
      disp_lz_q      <= 1'b0;
      disp_mask_q    <= '0;
      blank_all_q    <= 1'b1;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      scan_cnt_q     <= '0;
      digit_idx_q    <= '0;
      hex_out_q      <= '1;
      scan_seg_q     <= '1;
      scan_an_q      <= '1;
    end else begin
      state_q        <= state_d;
      shadow_value_q <= shadow_value_d;
      shadow_lz_q    <= shadow_lz_d;
      shadow_mask_q  <= shadow_mask_d;
      disp_value_q   <= disp_value_d;
      disp_lz_q      <= disp_lz_d;
      disp_mask_q    <= disp_mask_d;
      blank_all_q    <= blank_all_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      scan_cnt_q     <= scan_cnt_d;
      digit_idx_q    <= digit_idx_d;
      hex_out_q      <= hex_out_d;
      scan_seg_q     <= scan_seg_d;
      scan_an_q      <= scan_an_d;
    end
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit hexadecimal seven-segment display controller, the successor to the single-digit 3-bit decoder.
- Accepts a packed DIGITS×4-bit value over a valid/ready handshake and renders 0–F per digit on active-low segments.
- Adds per-digit blink, leading-zero suppression, and a time-multiplexed scan mode for boards with shared segment lines.
- Sits between datapath status registers and the board HEX outputs.

## Interface
- DIGITS, 4, number of digits; legal 1..8
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; ≥2
- SCAN_DIV, 50_000, clock cycles per digit in scan mode; ≥2
- SCAN_MODE, 0, 0 = static (one 7-bit group per digit), 1 = multiplexed scan
- CLOCK_50  in  1  system clock; one clock domain only
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  new display value offered
- in_ready  out  1  controller can accept; transfer on in_valid && in_ready at a rising edge
- in_value  in  4*DIGITS  digit i = in_value[4i+3:4i]; digit 0 least significant
- in_lz_blank  in  1  suppress leading zeros
- in_blink_mask  in  DIGITS  bit i set: digit i blinks
- hex_out  out  7*DIGITS  static-mode segments, active-low; digit i segment a..g at bits 7i+6..7i+0; all 1s when SCAN_MODE=1
- scan_seg  out  7  scan-mode segments, active-low, a..g at bits 6..0; all 1s when SCAN_MODE=0
- scan_an  out  DIGITS  scan-mode digit enables, active-low, one-hot-low; all 1s when SCAN_MODE=0

## Operation
- Segment patterns (active-low, a..g MSB first):
  - 0..7: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
  - 8..F: 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000
  - blank: 1111111
- Handshake FSM, states IDLE and COMMIT; in_ready = (state == IDLE).
  - IDLE: on transfer, capture in_value, in_lz_blank and in_blink_mask into shadow registers; go to COMMIT.
  - COMMIT, static mode: at the next edge, copy shadow to display registers, clear blank_all, return to IDLE.
  - COMMIT, scan mode: hold until the scan tick with digit index == DIGITS-1. At that edge, copy shadow to display and return to IDLE, so frames never tear.
- Leading-zero suppression: when enabled, digits from DIGITS-1 downward are blanked while their value is 0, stopping at the first non-zero digit. Digit 0 is never blanked by suppression.
- Blink counter counts 0..BLINK_DIV-1 and toggles blink_phase on wrap. While blink_phase == 1, digits with mask bit set are blanked.
- Scan counter counts 0..SCAN_DIV-1; the wrap cycle is the scan tick. On each tick, digit index advances, wrapping DIGITS-1 → 0.
  - scan_an bit index = 0, all others 1.
  - scan_seg = pattern of digit index.
- Counter widths are $clog2 of the divisor. Divisors wrap exactly; no off-by-one.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, so in_ready = 1
  - shadow and display registers 0, blank_all = 1
  - blink_phase 0, both counters 0, digit index 0
  - hex_out, scan_seg and scan_an all 1s
- Static-mode latency: transfer at edge k; display registers update at k+1; hex_out shows the new value after edge k+2. in_ready is low only between k and k+1.
- Scan-mode latency: the commit edge coincides with digit index wrapping to 0. The digit-0 pattern of the new value appears on scan_seg after the following edge.
- All outputs are registered; no combinational path from inputs to outputs.
- in_valid while in COMMIT is ignored; the source holds it.
- A blink toggle and a commit on the same edge both take effect; the new mask uses the toggled phase.
- Reset during COMMIT discards the shadow; the display returns to blank_all.
- Blink and scan counters free-run regardless of handshake activity.

## Structure
- Package hex_display_pkg holds:
  - the 16-entry segment pattern constant
  - the SEG_BLANK constant
  - the FSM state enum
- Sub-module seg7_hex_decoder: combinational, 4-bit value plus blank input to a 7-bit active-low pattern. Instantiated DIGITS times in static mode, once in scan mode.

## Test plan
Simulation parameters: DIGITS=4, BLINK_DIV=8, SCAN_DIV=4.

- Reset, then idle → hex_out = all 1s and in_ready = 1 with no transfer.
- Static: transfer 0x1A3F, lz off, mask 0 → after 2 cycles hex_out digits 3..0 = 1001111, 0001000, 0000110, 0111000; in_ready low exactly 1 cycle.
- Static: 0x0070 with lz on → digits 3 and 2 blank, digit 1 = 0001111, digit 0 = 0000001. Value 0x0000 with lz on → only digit 0 shown, as 0000001.
- Static: mask 0b0001, value 0x1234 → digit 0 alternates 1001100 and blank every 8 cycles; other digits steady.
- Scan: transfer mid-frame → new value first appears on scan_an = 1110 after index wraps. scan_an then cycles 1110, 1101, 1011, 0111 every 4 cycles.
- Assert rst_n low while in COMMIT → outputs all 1s immediately. After release, the display stays blank until a new transfer.
